// File: rtl/gesture_time_setter_pkg.sv
// Shared definitions for the gesture-window value: width, legal bounds,
// FSM state encoding and the binary-to-BCD helper used by the display path.
package gesture_time_setter_pkg;

  localparam int TIME_W = 6;

  // Defaults for the gesture window in seconds; the on/off control reads the same bounds
  localparam int unsigned GT_MIN_TIME     = 1;
  localparam int unsigned GT_MAX_TIME     = 60;
  localparam int unsigned GT_DEFAULT_TIME = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Split a 0..63 value into {tens, ones} BCD digits
  function automatic logic [7:0] to_bcd(input logic [TIME_W-1:0] value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 6'd10);
    ones = 4'(value % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/gesture_time_setter_key_repeat.sv
// Step generator for one adjustment key: one step on the rising edge, then
// after REPEAT_DELAY held cycles one step, then one every REPEAT_PERIOD cycles.
// Releasing the key or dropping enable clears the hold counter.
module gesture_time_setter_key_repeat #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic enable_i,
  output logic step_o
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic             key_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic             step;

  // Previous key level for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst) key_q <= 1'b0;
    else      key_q <= key_i;
  end

  // Hold counter: counts cycles since the edge (or since the last repeat step)
  always_comb begin
    cnt_d = '0;
    rep_d = 1'b0;
    step  = 1'b0;
    if (enable_i && key_i) begin
      if (!key_q) begin
        step  = 1'b1;
        cnt_d = CNT_W'(1);
      end else if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
                   ( rep_q && cnt_q == CNT_W'(REPEAT_PERIOD))) begin
        step  = 1'b1;
        cnt_d = CNT_W'(1);
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        rep_d = rep_q;
      end
    end
  end

  // Hold counter and repeat-phase registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign step_o = step;

endmodule

// File: rtl/gesture_time_setter.sv
// Gesture-window setter: set key enters EDIT, up/down adjust a working copy,
// confirm commits it, set/timeout/power-off cancel. Drives the committed value
// and registered BCD digits for the seven-segment display.
// Build option: define GESTURE_TIME_WRAP_EN to wrap at MIN/MAX instead of saturating.
module gesture_time_setter
  import gesture_time_setter_pkg::*;
#(
  parameter int unsigned MIN_TIME      = GT_MIN_TIME,
  parameter int unsigned MAX_TIME      = GT_MAX_TIME,
  parameter int unsigned DEFAULT_TIME  = GT_DEFAULT_TIME,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned EDIT_TIMEOUT  = 1_000_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              machine_state,
  input  logic              set_btn,
  input  logic              up_btn,
  input  logic              down_btn,
  input  logic              confirm_btn,
  output logic [TIME_W-1:0] gesture_time,
  output logic [TIME_W-1:0] edit_value,
  output logic              editing,
  output logic              update_pulse,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
);

  localparam int TO_W = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;
  localparam logic [TIME_W-1:0] MIN_V = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] DEF_V = TIME_W'(DEFAULT_TIME);

  state_t            state_q, state_d;
  logic              set_q, confirm_q;
  logic              set_edge, confirm_edge;
  logic [1:0]        key_lvl, key_step;
  logic              up_step, down_step, keys_enable;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              timeout_hit;
  logic [TIME_W-1:0] gesture_q, gesture_d;
  logic [TIME_W-1:0] edit_q, edit_d;
  logic              update_q, update_d;
  logic [7:0]        bcd_q, bcd_d;
  logic              in_edit, load_edit, do_commit, do_adjust;

  function automatic logic [TIME_W-1:0] step_up(input logic [TIME_W-1:0] v);
`ifdef GESTURE_TIME_WRAP_EN
    return (v >= MAX_V) ? MIN_V : v + 1'b1;
`else
    return (v >= MAX_V) ? MAX_V : v + 1'b1;
`endif
  endfunction

  function automatic logic [TIME_W-1:0] step_down(input logic [TIME_W-1:0] v);
`ifdef GESTURE_TIME_WRAP_EN
    return (v <= MIN_V) ? MAX_V : v - 1'b1;
`else
    return (v <= MIN_V) ? MIN_V : v - 1'b1;
`endif
  endfunction

  // Previous levels of the set and confirm keys for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      set_q     <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      set_q     <= set_btn;
      confirm_q <= confirm_btn;
    end
  end

  assign set_edge     = set_btn & ~set_q;
  assign confirm_edge = confirm_btn & ~confirm_q;

  // Both keys held means no adjustment and both hold counters cleared
  assign keys_enable = in_edit && !(up_btn && down_btn);
  assign key_lvl     = {down_btn, up_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      gesture_time_setter_key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_key_repeat (
        .clk      (clk),
        .rst      (rst),
        .key_i    (key_lvl[gi]),
        .enable_i (keys_enable),
        .step_o   (key_step[gi])
      );
    end
  endgenerate

  assign up_step     = key_step[0];
  assign down_step   = key_step[1];
  assign timeout_hit = (timeout_q == TO_W'(EDIT_TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; cancel priority: power-off, set, then confirm, then timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (set_edge && machine_state) state_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (!machine_state || set_edge) state_d = ST_IDLE;
        else if (confirm_edge)          state_d = ST_COMMIT;
        else if (timeout_hit)           state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: editing flag and datapath controls
  always_comb begin
    in_edit   = (state_q == ST_EDIT);
    load_edit = (state_q == ST_IDLE) && set_edge && machine_state;
    do_commit = (state_q == ST_COMMIT);
    do_adjust = in_edit && machine_state && !set_edge && !confirm_edge && !timeout_hit;
  end

  // Datapath next state: load working copy, adjust it, commit it, track idle time
  always_comb begin
    gesture_d = gesture_q;
    edit_d    = edit_q;
    update_d  = 1'b0;
    timeout_d = timeout_q;
    if (load_edit) begin
      edit_d    = gesture_q;
      timeout_d = '0;
    end
    if (in_edit) begin
      timeout_d = timeout_q + 1'b1;
    end
    if (do_adjust) begin
      if (up_step)        edit_d = step_up(edit_q);
      else if (down_step) edit_d = step_down(edit_q);
      if (up_step || down_step) timeout_d = '0;
    end
    if (do_commit) begin
      gesture_d = edit_q;
      update_d  = (edit_q != gesture_q);
    end
  end

  // Display source follows the working copy only while editing
  always_comb begin
    bcd_d = to_bcd(in_edit ? edit_q : gesture_q);
  end

  // Datapath and display registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      gesture_q <= DEF_V;
      edit_q    <= DEF_V;
      update_q  <= 1'b0;
      timeout_q <= '0;
      bcd_q     <= to_bcd(DEF_V);
    end else begin
      gesture_q <= gesture_d;
      edit_q    <= edit_d;
      update_q  <= update_d;
      timeout_q <= timeout_d;
      bcd_q     <= bcd_d;
    end
  end

  assign gesture_time = gesture_q;
  assign edit_value   = edit_q;
  assign editing      = in_edit;
  assign update_pulse = update_q;
  assign bcd_tens     = bcd_q[7:4];
  assign bcd_ones     = bcd_q[3:0];

endmodule

// File: tb/tb_gesture_time_setter.sv
// Directed bench for gesture_time_setter with short repeat/timeout constants.
// A per-cycle vector table covers edit/commit/cancel; hand sequences cover
// auto-repeat at the upper bound, idle timeout and reset mid-edit.
module tb_gesture_time_setter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       machine_state = 1'b0;
  logic       set_btn = 1'b0;
  logic       up_btn = 1'b0;
  logic       down_btn = 1'b0;
  logic       confirm_btn = 1'b0;
  logic [5:0] gesture_time, edit_value;
  logic       editing, update_pulse;
  logic [3:0] bcd_tens, bcd_ones;

  int checks = 0;
  int errors = 0;

  gesture_time_setter #(
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5),
    .EDIT_TIMEOUT  (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .machine_state (machine_state),
    .set_btn       (set_btn),
    .up_btn        (up_btn),
    .down_btn      (down_btn),
    .confirm_btn   (confirm_btn),
    .gesture_time  (gesture_time),
    .edit_value    (edit_value),
    .editing       (editing),
    .update_pulse  (update_pulse),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ms, set, up, dn, cf;
    logic [5:0] g, e;
    logic       ed, upd;
    logic [3:0] bt, bo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ms, input logic set, input logic up,
                              input logic dn, input logic cf, input int g, input int e,
                              input logic ed, input logic upd, input int bt, input int bo);
    vec_t v;
    v.ms = ms; v.set = set; v.up = up; v.dn = dn; v.cf = cf;
    v.g = 6'(g); v.e = 6'(e); v.ed = ed; v.upd = upd; v.bt = 4'(bt); v.bo = 4'(bo);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int g, input int e, input int ed,
                         input int upd, input int bt, input int bo);
    chk({tag, ".gesture_time"}, int'(gesture_time), g);
    chk({tag, ".edit_value"},   int'(edit_value), e);
    chk({tag, ".editing"},      int'(editing), ed);
    chk({tag, ".update_pulse"}, int'(update_pulse), upd);
    chk({tag, ".bcd_tens"},     int'(bcd_tens), bt);
    chk({tag, ".bcd_ones"},     int'(bcd_ones), bo);
  endtask

  function automatic int model_up(input int v);
`ifdef GESTURE_TIME_WRAP_EN
    return (v == 60) ? 1 : v + 1;
`else
    return (v == 60) ? 60 : v + 1;
`endif
  endfunction

  int exp_v;
  int exp_g;
  int step_now;

  initial begin
    // columns: ms set up dn cf | gesture edit editing update tens ones
    vecs.push_back(mk(1,0,0,0,0, 5,5,0,0,0,5));  // idle
    vecs.push_back(mk(1,1,0,0,0, 5,5,1,0,0,5));  // set edge -> EDIT
    vecs.push_back(mk(1,0,0,0,0, 5,5,1,0,0,5));
    vecs.push_back(mk(1,0,1,0,0, 5,6,1,0,0,5));  // up
    vecs.push_back(mk(1,0,0,0,0, 5,6,1,0,0,6));
    vecs.push_back(mk(1,0,1,0,0, 5,7,1,0,0,6));  // up
    vecs.push_back(mk(1,0,0,0,0, 5,7,1,0,0,7));
    vecs.push_back(mk(1,0,1,0,0, 5,8,1,0,0,7));  // up
    vecs.push_back(mk(1,0,0,0,0, 5,8,1,0,0,8));
    vecs.push_back(mk(1,0,0,0,1, 5,8,0,0,0,8));  // confirm -> COMMIT
    vecs.push_back(mk(1,0,0,0,0, 8,8,0,1,0,5));  // commit, display shows old value once
    vecs.push_back(mk(1,0,0,0,0, 8,8,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0, 8,8,1,0,0,8));  // edit again
    vecs.push_back(mk(1,0,0,1,0, 8,7,1,0,0,8));  // down
    vecs.push_back(mk(1,0,0,0,0, 8,7,1,0,0,7));
    vecs.push_back(mk(1,0,0,1,0, 8,6,1,0,0,7));  // down
    vecs.push_back(mk(1,0,0,0,0, 8,6,1,0,0,6));
    vecs.push_back(mk(1,1,0,0,0, 8,6,0,0,0,6));  // set edge cancels
    vecs.push_back(mk(1,0,0,0,0, 8,6,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0, 8,8,1,0,0,8));  // edit, no change
    vecs.push_back(mk(1,0,0,0,0, 8,8,1,0,0,8));
    vecs.push_back(mk(1,0,0,0,1, 8,8,0,0,0,8));  // confirm
    vecs.push_back(mk(1,0,0,0,0, 8,8,0,0,0,8));  // commit without update pulse
    vecs.push_back(mk(0,1,0,0,0, 8,8,0,0,0,8));  // set while off: ignored
    vecs.push_back(mk(0,0,0,0,0, 8,8,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0, 8,8,1,0,0,8));  // edit
    vecs.push_back(mk(1,0,1,0,0, 8,9,1,0,0,8));  // up
    vecs.push_back(mk(0,0,0,0,0, 8,9,0,0,0,9));  // power drop cancels
    vecs.push_back(mk(1,0,0,0,0, 8,9,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0, 8,8,1,0,0,8));  // edit
    vecs.push_back(mk(1,0,1,1,0, 8,8,1,0,0,8));  // both keys: no change
    vecs.push_back(mk(1,0,1,1,0, 8,8,1,0,0,8));
    vecs.push_back(mk(1,0,0,0,0, 8,8,1,0,0,8));
    vecs.push_back(mk(1,1,0,0,0, 8,8,0,0,0,8));  // cancel
    vecs.push_back(mk(1,0,0,0,0, 8,8,0,0,0,8));

    // reset state
    repeat (3) tick();
    chk_all("reset", 5, 5, 0, 0, 0, 5);
    rst = 1'b1;

    foreach (vecs[i]) begin
      machine_state = vecs[i].ms;
      set_btn       = vecs[i].set;
      up_btn        = vecs[i].up;
      down_btn      = vecs[i].dn;
      confirm_btn   = vecs[i].cf;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].g), int'(vecs[i].e), int'(vecs[i].ed),
              int'(vecs[i].upd), int'(vecs[i].bt), int'(vecs[i].bo));
      $display("vec %0d: g=%0d e=%0d ed=%0d upd=%0d bcd=%0d%0d", i, gesture_time,
               edit_value, editing, update_pulse, bcd_tens, bcd_ones);
    end

    // raise the committed value to 58 with 50 single presses
    set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
    for (int i = 0; i < 50; i++) begin
      up_btn = 1'b1; tick(); up_btn = 1'b0; tick();
    end
    confirm_btn = 1'b1; tick(); confirm_btn = 1'b0; tick();
    chk("build58.gesture_time", int'(gesture_time), 58);
    chk("build58.update_pulse", int'(update_pulse), 1);
    tick();
    chk("build58.bcd_tens", int'(bcd_tens), 5);
    chk("build58.bcd_ones", int'(bcd_ones), 8);
    $display("build: gesture_time=%0d bcd=%0d%0d", gesture_time, bcd_tens, bcd_ones);

    // hold up for 40 cycles starting at 58
    set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
    exp_v = 58;
    up_btn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      step_now = ((k == 0) || (k >= 20 && (k - 20) % 5 == 0)) ? 1 : 0;
      if (step_now != 0) exp_v = model_up(exp_v);
      chk($sformatf("hold%0d.edit_value", k), int'(edit_value), exp_v);
    end
    up_btn = 1'b0;
    tick();
    chk("hold_release.edit_value", int'(edit_value), exp_v);
    confirm_btn = 1'b1; tick(); confirm_btn = 1'b0; tick();
    chk("hold_commit.gesture_time", int'(gesture_time), exp_v);
    chk("hold_commit.update_pulse", int'(update_pulse), 1);
    tick();
    chk("hold_commit.bcd_tens", int'(bcd_tens), exp_v / 10);
    chk("hold_commit.bcd_ones", int'(bcd_ones), exp_v % 10);
    $display("hold: final value=%0d gesture_time=%0d", exp_v, gesture_time);
    exp_g = exp_v;

    // idle timeout: one down step, then 100 quiet cycles
    set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
    down_btn = 1'b1; tick(); down_btn = 1'b0;
    chk("timeout.edit_after_down", int'(edit_value), exp_g - 1);
    repeat (99) tick();
    chk("timeout.editing_before", int'(editing), 1);
    tick();
    chk("timeout.editing_after", int'(editing), 0);
    chk("timeout.gesture_time", int'(gesture_time), exp_g);
    chk("timeout.update_pulse", int'(update_pulse), 0);
    tick();
    chk("timeout.update_pulse_late", int'(update_pulse), 0);
    $display("timeout: editing=%0d gesture_time=%0d", editing, gesture_time);

    // reset in the middle of an edit
    set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
    down_btn = 1'b1; tick();
    rst = 1'b0; tick();
    chk_all("rst_mid_edit", 5, 5, 0, 0, 0, 5);
    rst = 1'b1; down_btn = 1'b0; tick();
    chk("rst_mid_edit.after", int'(editing), 0);
    $display("reset mid-edit: gesture_time=%0d editing=%0d", gesture_time, editing);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
